rnd_req_arbiter: RTL and testbench
==================================

Name: rnd_req_arbiter

Overview:
- Controller and round-robin arbiter that shares one rnd_vec_gen instance among NREQ requesters.
- Sequences the generator control strobes (init, save, restore, next). Captures the generator output after a fixed settle latency and returns it to the granted requester with a one-cycle ack.
- Sits between the top-level consumers (PWM/LED effects, test logic) and rnd_vec_gen, replacing ad-hoc control FSMs in top modules.

Parameters:
- NREQ, 3, number of requesters (2..8).
- WIDTH, 16, generator output width.
- GEN_LAT, 2, cycles from gen_next strobe to valid gen_out (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  per-requester level request; held until ack
- ack  out  NREQ  one-hot, 1-cycle pulse; data_out valid in same cycle
- data_out  out  WIDTH  random word for the acked requester
- replay  in  1  1-cycle pulse: restore saved seed state (sequence replay)
- busy  out  1  high in every state except IDLE
- gen_init  out  1  to rnd_vec_gen.init
- gen_save  out  1  to rnd_vec_gen.save
- gen_restore  out  1  to rnd_vec_gen.restore
- gen_next  out  1  to rnd_vec_gen.next
- gen_out  in  WIDTH  from rnd_vec_gen.out

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=INIT; all gen_* = 0; ack = 0; data_out = 0; busy = 1.
  - RR pointer = requester 0 has highest priority; replay_pend = 0; wait counter = 0.
- Every gen_* output is a single-cycle registered strobe. At most one gen_* is high in any cycle.
- FSM (registered outputs assert in the cycle the state is entered):
  - INIT: gen_init=1 for one cycle -> SAVE.
  - SAVE: gen_save=1 for one cycle -> IDLE. Stores the post-init seed for replay.
  - IDLE: busy=0.
    - If replay_pend or replay -> RESTORE.
    - Else if any req -> grant the RR winner, latch its index -> STEP.
    - Else stay in IDLE.
  - STEP: gen_next=1 for one cycle; load counter=GEN_LAT-1 -> WAIT.
  - WAIT: decrement counter. At 0 -> DELIVER.
  - DELIVER: data_out<=gen_out; ack[grant]=1 for one cycle; pointer<=grant+1 (mod NREQ) -> IDLE.
  - RESTORE: gen_restore=1 for one cycle; replay_pend<=0 -> IDLE.
- Round-robin rule: search starts at the pointer and wraps modulo NREQ. The first requester found with req high wins.
- Grant latency: req seen in IDLE -> ack exactly GEN_LAT+2 cycles later.
- Back-to-back service: IDLE must be visited for one cycle between transactions. Minimum period per word is GEN_LAT+3 cycles.
- A requester deasserts req in the cycle after ack. If req is still high in the next IDLE, it is treated as a new request subject to RR.
- A req dropped before ack is ignored once granted. The transaction still completes and the ack pulses regardless. data_out holds its value until the next DELIVER.
- replay arriving outside IDLE sets replay_pend. It is served at the next IDLE before any req. Multiple replays while pending collapse into one.
- replay and req in the same IDLE cycle: replay wins. The req is served after RESTORE.
- Bits of req at or above NREQ do not exist. Requests are not reordered beyond the RR rule.

Test Plan:
- Reset then idle:
  - Assert rst for 3 cycles, release.
  - Required: gen_init pulse in cycle 1, gen_save in cycle 2, busy=0 from cycle 3, ack=0, data_out=0.
- Single request:
  - GEN_LAT=2, model gen_out=0xA5C3 two cycles after gen_next; req=3'b010 held.
  - Required: gen_next 1 cycle after IDLE, ack=3'b010 with data_out=0xA5C3 exactly 4 cycles after req is sampled in IDLE.
- Round-robin fairness:
  - req=3'b111 held continuously (re-asserted after each ack).
  - Required: ack order 001, 010, 100, 001, … with spacing of 5 cycles.
- Replay priority:
  - replay pulse during WAIT of a req0 transaction.
  - Required: req0 acked normally, then gen_restore pulses in the cycle after IDLE before the next gen_next. A following run of 3 words matches the first 3 words after SAVE.
- Simultaneous replay and req:
  - replay=1 and req=3'b001 in the same IDLE cycle.
  - Required: gen_restore first, gen_next 2 cycles later, then ack=001.
- Async reset mid-transaction:
  - Assert rst in WAIT.
  - Required: ack never pulses, all gen_* drop in the same cycle, the INIT/SAVE sequence repeats, pointer returns to 0.

Source files
------------

// File: rtl/rnd_req_arbiter.sv
// Round-robin front end for a shared rnd_vec_gen.
// Sequences init/save/restore/next strobes and returns one word per grant.
module rnd_req_arbiter #(
    parameter int NREQ    = 3,
    parameter int WIDTH   = 16,
    parameter int GEN_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [WIDTH-1:0] data_out,
    input  logic             replay,
    output logic             busy,
    output logic             gen_init,
    output logic             gen_save,
    output logic             gen_restore,
    output logic             gen_next,
    input  logic [WIDTH-1:0] gen_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;
    localparam logic [CW-1:0] LAT_M1 = CW'(GEN_LAT - 1);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_SAVE,
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DELIVER,
        S_RESTORE
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    logic          found;
    logic          replay_pend;
    logic [CW-1:0] cnt;

    // Circular search beginning at ptr; first set req bit wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == LAST) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT;
            ptr         <= '0;
            grant       <= '0;
            replay_pend <= 1'b0;
            cnt         <= '0;
            ack         <= '0;
            data_out    <= '0;
            busy        <= 1'b1;
            gen_init    <= 1'b0;
            gen_save    <= 1'b0;
            gen_restore <= 1'b0;
            gen_next    <= 1'b0;
        end else begin
            gen_init    <= 1'b0;
            gen_save    <= 1'b0;
            gen_restore <= 1'b0;
            gen_next    <= 1'b0;
            ack         <= '0;
            busy        <= 1'b1;
            unique case (state)
                S_INIT: begin
                    gen_init <= 1'b1;
                    state    <= S_SAVE;
                end
                S_SAVE: begin
                    gen_save <= 1'b1;
                    state    <= S_IDLE;
                end
                S_IDLE: begin
                    busy <= 1'b0;
                    if (replay_pend || replay) begin
                        state <= S_RESTORE;
                    end else if (found) begin
                        grant <= winner;
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    gen_next <= 1'b1;
                    cnt      <= LAT_M1;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_DELIVER;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DELIVER: begin
                    data_out <= gen_out;
                    ack      <= NREQ'(1) << grant;
                    ptr      <= (grant == LAST) ? '0 : grant + IW'(1);
                    state    <= S_IDLE;
                end
                S_RESTORE: begin
                    gen_restore <= 1'b1;
                    replay_pend <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
            // A replay seen while busy is remembered; repeats collapse.
            if (replay && state != S_IDLE) begin
                replay_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rnd_req_arbiter.sv
// Bench for rnd_req_arbiter with a behavioural generator stand-in.
// Directed scenarios plus a random run against a timeline model.
module tb_rnd_req_arbiter;

    localparam int NREQ    = 3;
    localparam int WIDTH   = 16;
    localparam int GEN_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [WIDTH-1:0] data_out;
    logic             replay;
    logic             busy;
    logic             gen_init;
    logic             gen_save;
    logic             gen_restore;
    logic             gen_next;
    logic [WIDTH-1:0] gen_out;

    int n_cmp = 0;
    int n_bad = 0;

    int          t_ptr;
    int          t_widx;
    logic [15:0] t_last;

    always #5 clk = ~clk;

    rnd_req_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .GEN_LAT(GEN_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .ack(ack),
        .data_out(data_out),
        .replay(replay),
        .busy(busy),
        .gen_init(gen_init),
        .gen_save(gen_save),
        .gen_restore(gen_restore),
        .gen_next(gen_next),
        .gen_out(gen_out)
    );

    // Word n of the sequence after init; word(1) is the first delivered.
    function automatic logic [15:0] word(input int n);
        return 16'hA5C3 ^ 16'((n - 1) * 40503);
    endfunction

    // Generator stand-in: index state, output valid GEN_LAT after next.
    int gn = 0;
    int gsaved = 0;
    always @(posedge clk) begin
        if (gen_init) gn <= 0;
        else if (gen_save) gsaved <= gn;
        else if (gen_restore) gn <= gsaved;
        else if (gen_next) gn <= gn + 1;
        gen_out <= word(gn);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [2:0] m, output logic [2:0] a,
                         output logic [15:0] d, output int lat);
        req = m;
        a   = '0;
        d   = '0;
        lat = -1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack !== 3'b000) begin
                a   = ack;
                d   = data_out;
                lat = k;
                break;
            end
        end
        req = '0;
    endtask

    task automatic test_reset();
        logic [3:0] g;
        rst = 1'b1;
        req = '0;
        replay = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if ({busy, gen_init, gen_save, gen_restore, gen_next} !== 5'b10000
                || ack !== 3'b000 || data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_hold: busy=%b gen=%b%b%b%b ack=%b data=%h required busy=1 gen=0000 ack=000 data=0000",
                         busy, gen_init, gen_save, gen_restore, gen_next, ack, data_out);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            g = (k == 1) ? 4'b1000 : (k == 2) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if ({gen_init, gen_save, gen_restore, gen_next} !== g
                || busy !== (k < 3) || ack !== 3'b000 || data_out !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_seq c%0d: gen=%b%b%b%b busy=%b ack=%b data=%h required gen=%b busy=%b ack=000 data=0000",
                         k, gen_init, gen_save, gen_restore, gen_next, busy, ack, data_out, g, k < 3);
            end
        end
        t_ptr = 0;
        t_widx = 0;
        t_last = 16'h0000;
    endtask

    task automatic test_single();
        req = 3'b010;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (gen_next !== (k == 1) || ack !== ((k == 4) ? 3'b010 : 3'b000)) begin
                n_bad++;
                $display("FAIL single c%0d: next=%b ack=%b required next=%b ack=%b",
                         k, gen_next, ack, k == 1, (k == 4) ? 3'b010 : 3'b000);
            end
        end
        n_cmp++;
        if (data_out !== 16'hA5C3) begin
            n_bad++;
            $display("FAIL single_data: got %h required a5c3", data_out);
        end
        req = '0;
        t_last = 16'hA5C3;
        t_widx = 1;
        t_ptr = 2;
        tick();
        n_cmp++;
        if (ack !== 3'b000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: ack=%b busy=%b required ack=000 busy=0", ack, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        req = 3'b111;
        tick();
        for (int k = 1; k <= 29; k++) begin
            tick();
            exp = (k % 5 == 4) ? 3'(1 << ((t_ptr + k / 5) % 3)) : 3'b000;
            n_cmp++;
            if (ack !== exp) begin
                n_bad++;
                $display("FAIL rr_ack c%0d: got %b required %b", k, ack, exp);
            end
            if (k % 5 == 4) begin
                t_widx++;
                t_last = word(t_widx);
                n_cmp++;
                if (data_out !== t_last) begin
                    n_bad++;
                    $display("FAIL rr_data c%0d: got %h required %h", k, data_out, t_last);
                end
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_replay();
        logic [2:0]  a;
        logic [15:0] d;
        int          lat;
        req = 3'b001;
        tick();
        tick();
        replay = 1'b1;
        tick();
        replay = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (ack !== 3'b001 || data_out !== word(t_widx + 1)) begin
            n_bad++;
            $display("FAIL replay_first: ack=%b data=%h required ack=001 data=%h",
                     ack, data_out, word(t_widx + 1));
        end
        req = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || gen_restore !== 1'b0) begin
            n_bad++;
            $display("FAIL replay_idle: busy=%b restore=%b required busy=0 restore=0", busy, gen_restore);
        end
        tick();
        n_cmp++;
        if (gen_restore !== 1'b1 || gen_next !== 1'b0) begin
            n_bad++;
            $display("FAIL replay_restore: restore=%b next=%b required restore=1 next=0", gen_restore, gen_next);
        end
        tick();
        for (int j = 1; j <= 3; j++) begin
            serve(3'b001, a, d, lat);
            n_cmp++;
            if (a !== 3'b001 || d !== word(j) || lat !== 4) begin
                n_bad++;
                $display("FAIL replay_word%0d: ack=%b data=%h lat=%0d required ack=001 data=%h lat=4",
                         j, a, d, lat, word(j));
            end
        end
        t_widx = 3;
        t_last = word(3);
        t_ptr = 1;
    endtask

    task automatic test_simul();
        replay = 1'b1;
        req = 3'b001;
        tick();
        replay = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if (gen_restore !== (k == 1) || gen_next !== (k == 3)
                || ack !== ((k == 6) ? 3'b001 : 3'b000)) begin
                n_bad++;
                $display("FAIL simul c%0d: restore=%b next=%b ack=%b required restore=%b next=%b ack=%b",
                         k, gen_restore, gen_next, ack, k == 1, k == 3, (k == 6) ? 3'b001 : 3'b000);
            end
        end
        n_cmp++;
        if (data_out !== word(1)) begin
            n_bad++;
            $display("FAIL simul_data: got %h required %h", data_out, word(1));
        end
        req = '0;
        t_widx = 1;
        t_last = word(1);
        t_ptr = 1;
        tick();
    endtask

    task automatic test_async_reset();
        logic [2:0]  a;
        logic [15:0] d;
        int          lat;
        logic [1:0]  g;
        req = 3'b001;
        tick();
        tick();
        n_cmp++;
        if (gen_next !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre: next=%b required 1", gen_next);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({gen_init, gen_save, gen_restore, gen_next} !== 4'b0000
            || ack !== 3'b000 || busy !== 1'b1 || data_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL arst_now: gen=%b%b%b%b ack=%b busy=%b data=%h required gen=0000 ack=000 busy=1 data=0000",
                     gen_init, gen_save, gen_restore, gen_next, ack, busy, data_out);
        end
        req = '0;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            g = (k == 1) ? 2'b10 : (k == 2) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({gen_init, gen_save} !== g || ack !== 3'b000 || busy !== (k < 3)) begin
                n_bad++;
                $display("FAIL arst_seq c%0d: init/save=%b ack=%b busy=%b required %b ack=000 busy=%b",
                         k, {gen_init, gen_save}, ack, busy, g, k < 3);
            end
        end
        for (int j = 0; j < 3; j++) begin
            serve(3'b111, a, d, lat);
            n_cmp++;
            if (a !== 3'(1 << j) || d !== word(j + 1) || lat !== 4) begin
                n_bad++;
                $display("FAIL arst_rr%0d: ack=%b data=%h lat=%0d required ack=%b data=%h lat=4",
                         j, a, d, lat, 3'(1 << j), word(j + 1));
            end
        end
        t_ptr = 0;
        t_widx = 3;
        t_last = word(3);
    endtask

    task automatic test_random();
        int          e;
        int          next_idle;
        int          ack_e;
        int          rst_e;
        int          nxt_e;
        int          ack_w;
        int          w;
        int          ptr;
        int          widx;
        logic        pend;
        logic        p;
        logic        idle_now;
        logic [2:0]  r;
        logic [2:0]  ack_m;
        logic [2:0]  exp_a;
        logic [15:0] last;
        ptr = t_ptr;
        widx = t_widx;
        last = t_last;
        e = 0;
        next_idle = 1;
        ack_e = -1;
        rst_e = -1;
        nxt_e = -1;
        ack_w = 0;
        ack_m = '0;
        pend = 1'b0;
        req = '0;
        replay = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(15) == 0) req[i] = 1'b0;
            end
            replay = ($urandom_range(24) == 0);
            r = req;
            p = replay;
            tick();
            e++;
            exp_a = (e == ack_e) ? ack_m : 3'b000;
            if (e == ack_e) last = word(ack_w);
            idle_now = (e == next_idle);
            if (idle_now) begin
                if (pend || p) begin
                    pend = 1'b0;
                    rst_e = e + 1;
                    widx = 0;
                    next_idle = e + 2;
                end else if (r != 3'b000) begin
                    w = -1;
                    for (int j = 0; j < NREQ; j++)
                        if (w < 0 && r[(ptr + j) % NREQ]) w = (ptr + j) % NREQ;
                    widx++;
                    ack_w = widx;
                    ack_m = 3'(1 << w);
                    ack_e = e + GEN_LAT + 2;
                    nxt_e = e + 1;
                    ptr = (w + 1) % NREQ;
                    next_idle = e + GEN_LAT + 3;
                end else begin
                    next_idle = e + 1;
                end
            end else if (p) begin
                pend = 1'b1;
            end
            n_cmp++;
            if (ack !== exp_a || data_out !== last || gen_restore !== (e == rst_e)
                || gen_next !== (e == nxt_e) || busy !== !idle_now
                || gen_init !== 1'b0 || gen_save !== 1'b0) begin
                n_bad++;
                $display("FAIL random e%0d: ack=%b data=%h rst=%b nxt=%b busy=%b required ack=%b data=%h rst=%b nxt=%b busy=%b",
                         e, ack, data_out, gen_restore, gen_next, busy,
                         exp_a, last, e == rst_e, e == nxt_e, !idle_now);
            end
            req = req & ~exp_a;
        end
        req = '0;
        replay = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_replay();
        test_simul();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
